// File: rtl/sm83_bus_responder.sv
// sm83_bus_responder: memory-side responder for the sm83_core bus.
// Decodes ROM, WRAM (with echo), OAM, HRAM, IE and the FF46 DMA register.
// Reads are combinational. Writes commit on the rising clock edge.
// Optional feature macro: SM83_BUS_OAM_DMA_EN
//   When defined, FF46 starts a 160-byte OAM DMA that blocks the core bus
//   (HRAM excepted) while it runs.
//   When undefined, FF46 is a plain register and the bus is never blocked.
module sm83_bus_responder #(
    parameter int         WRAM_AW      = 13,
    parameter logic [7:0] UNMAPPED_VAL = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] r_addr,
    input  logic [15:0] w_addr,
    input  logic [7:0]  w_data,
    input  logic        w_wen,
    output logic [7:0]  r_data,
    output logic [14:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        dma_active
);

    localparam int WRAM_SZ = 1 << WRAM_AW;

    logic [7:0]  r_wram [0:WRAM_SZ-1];
    logic [7:0]  r_oam  [0:159];
    logic [7:0]  r_hram [0:126];
    logic [7:0]  r_ff46;
    logic [7:0]  r_ie;

    logic        w_dma_busy;
    logic [15:0] w_dma_src;
    logic [7:0]  w_dma_idx;
    logic [7:0]  w_dma_rdata;
    logic        w_core_wr_ok;

    function automatic logic f_is_wram(input logic [15:0] a);
        return (a >= 16'hC000) && (a <= 16'hFDFF);
    endfunction

    function automatic logic f_is_oam(input logic [15:0] a);
        return (a >= 16'hFE00) && (a <= 16'hFE9F);
    endfunction

    function automatic logic f_is_hram(input logic [15:0] a);
        return (a >= 16'hFF80) && (a <= 16'hFFFE);
    endfunction

    // Shared read path used by both the core and the DMA engine. ROM data
    // always corresponds to rom_addr, which is steered to whichever of the
    // two is currently allowed to see the bus.
    function automatic logic [7:0] f_read(input logic [15:0] a);
        logic [7:0] d;
        d = UNMAPPED_VAL;
        if (a[15] == 1'b0) begin
            d = rom_data;
        end else if (f_is_wram(a)) begin
            // Echo E000-FDFF shares its low bits with C000-DDFF
            d = r_wram[a[WRAM_AW-1:0]];
        end else if (f_is_oam(a)) begin
            d = r_oam[a[7:0]];
        end else if (a == 16'hFF46) begin
            d = r_ff46;
        end else if (f_is_hram(a)) begin
            d = r_hram[a[6:0]];
        end else if (a == 16'hFFFF) begin
            d = r_ie;
        end
        return d;
    endfunction

`ifdef SM83_BUS_OAM_DMA_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_ACTIVE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_src_h;
    logic [7:0]  r_idx;
    logic        r_dma_active;

    // DMA FSM: a write to FF46 (re)starts the transfer from any state;
    // START lasts one cycle, then 160 ACTIVE cycles copy idx 0..159.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_src_h      <= 8'h00;
            r_idx        <= 8'd0;
            r_ff46       <= 8'h00;
            r_dma_active <= 1'b0;
        end else if (w_wen && (w_addr == 16'hFF46)) begin
            r_ff46       <= w_data;
            // Sources above DFxx fold back through the echo region
            r_src_h      <= (w_data <= 8'hDF) ? w_data : (w_data - 8'h20);
            r_idx        <= 8'd0;
            r_state      <= S_START;
            r_dma_active <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dma_active <= 1'b0;
                end
                S_START: begin
                    r_state      <= S_ACTIVE;
                    r_dma_active <= 1'b1;
                end
                S_ACTIVE: begin
                    if (r_idx == 8'd159) begin
                        r_state      <= S_IDLE;
                        r_idx        <= 8'd0;
                        r_dma_active <= 1'b0;
                    end else begin
                        r_idx        <= r_idx + 8'd1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_dma_active <= 1'b0;
                end
            endcase
        end
    end

    assign w_dma_busy = (r_state == S_ACTIVE);
    assign w_dma_src  = {r_src_h, r_idx};
    assign w_dma_idx  = r_idx;
    assign dma_active = r_dma_active;
`else
    // FF46 is an ordinary read/write register when DMA is compiled out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ff46 <= 8'h00;
        end else if (w_wen && (w_addr == 16'hFF46)) begin
            r_ff46 <= w_data;
        end
    end

    assign w_dma_busy = 1'b0;
    assign w_dma_src  = 16'h0000;
    assign w_dma_idx  = 8'd0;
    assign dma_active = 1'b0;
`endif

    // Only HRAM stays reachable by the core while a transfer is copying
    assign w_core_wr_ok = w_wen && (!w_dma_busy || f_is_hram(w_addr));
    assign rom_addr     = w_dma_busy ? w_dma_src[14:0] : r_addr[14:0];

    // Combinational read data for the core and for the DMA engine
    always_comb begin
        r_data      = f_read(r_addr);
        w_dma_rdata = f_read(w_dma_src);
        if (w_dma_busy && !f_is_hram(r_addr)) begin
            r_data = UNMAPPED_VAL;
        end
    end

    // IE register, writable only when the bus is not blocked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ie <= 8'h00;
        end else if (w_core_wr_ok && (w_addr == 16'hFFFF)) begin
            r_ie <= w_data;
        end
    end

    // RAM array writes; contents are intentionally not reset. A core OAM
    // write cannot collide with the DMA write because the core is blocked.
    always_ff @(posedge clk) begin
        if (w_core_wr_ok) begin
            if (f_is_wram(w_addr)) begin
                r_wram[w_addr[WRAM_AW-1:0]] <= w_data;
            end
            if (f_is_oam(w_addr)) begin
                r_oam[w_addr[7:0]] <= w_data;
            end
            if (f_is_hram(w_addr)) begin
                r_hram[w_addr[6:0]] <= w_data;
            end
        end
        if (w_dma_busy) begin
            r_oam[w_dma_idx] <= w_dma_rdata;
        end
    end

endmodule

// File: tb/tb_sm83_bus_responder.sv
// Directed testbench for sm83_bus_responder. Expectations adapt to whether
// SM83_BUS_OAM_DMA_EN is defined for the build.
module tb_sm83_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] r_addr;
    logic [15:0] w_addr;
    logic [7:0]  w_data;
    logic        w_wen;
    logic [7:0]  r_data;
    logic [14:0] rom_addr;
    logic [7:0]  rom_data;
    logic        dma_active;

    int checks = 0;
    int errors = 0;

    sm83_bus_responder #(
        .WRAM_AW      (13),
        .UNMAPPED_VAL (8'hFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .r_addr     (r_addr),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .w_wen      (w_wen),
        .r_data     (r_data),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;

    // Simple combinational ROM model
    function automatic logic [7:0] rom_fn(input logic [14:0] a);
        return a[7:0] ^ {1'b0, a[14:8]};
    endfunction

    assign rom_data = rom_fn(rom_addr);

    function automatic logic [7:0] c1_byte(input int i);
        return 8'(i) ^ 8'hA5;
    endfunction

    function automatic logic [7:0] c2_byte(input int i);
        return 8'(i * 7 + 3);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        w_addr = a;
        w_data = d;
        w_wen  = 1'b1;
        tick();
        w_wen  = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        r_addr = a;
        #1;
        d = r_data;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (dma_active !== 1'b0) begin
            errors++;
            $display("FAIL reset_dma_active: got %b expected 0", dma_active);
        end
        rd(16'hFF46, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL reset_ff46: got %h expected 00", d);
        end
        rd(16'hFFFF, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL reset_ie: got %h expected 00", d);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_wram_echo();
        logic [7:0] d;
        wr(16'hC123, 8'h5A);
        rd(16'hC123, d);
        checks++;
        if (d !== 8'h5A) begin
            errors++;
            $display("FAIL wram_c123: got %h expected 5a", d);
        end
        rd(16'hE123, d);
        checks++;
        if (d !== 8'h5A) begin
            errors++;
            $display("FAIL echo_e123: got %h expected 5a", d);
        end
        wr(16'hE200, 8'h77);
        rd(16'hC200, d);
        checks++;
        if (d !== 8'h77) begin
            errors++;
            $display("FAIL echo_write_c200: got %h expected 77", d);
        end
    endtask

    task automatic test_rom();
        logic [7:0] d;
        rd(16'h1234, d);
        checks++;
        if (rom_addr !== 15'h1234) begin
            errors++;
            $display("FAIL rom_addr: got %h expected 1234", rom_addr);
        end
        checks++;
        if (d !== 8'h26) begin
            errors++;
            $display("FAIL rom_data: got %h expected 26", d);
        end
        wr(16'h1234, 8'h99);
        rd(16'h1234, d);
        checks++;
        if (d !== 8'h26) begin
            errors++;
            $display("FAIL rom_write_ignored: got %h expected 26", d);
        end
        rd(16'hC123, d);
        checks++;
        if (d !== 8'h5A) begin
            errors++;
            $display("FAIL rom_write_wram_intact: got %h expected 5a", d);
        end
    endtask

    task automatic test_hram_ie_unmapped();
        logic [7:0] d;
        wr(16'hFF80, 8'h11);
        wr(16'hFFFE, 8'h22);
        wr(16'hFFFF, 8'h1F);
        wr(16'hFEA0, 8'h33);
        rd(16'hFF80, d);
        checks++;
        if (d !== 8'h11) begin
            errors++;
            $display("FAIL hram_ff80: got %h expected 11", d);
        end
        rd(16'hFFFE, d);
        checks++;
        if (d !== 8'h22) begin
            errors++;
            $display("FAIL hram_fffe: got %h expected 22", d);
        end
        rd(16'hFFFF, d);
        checks++;
        if (d !== 8'h1F) begin
            errors++;
            $display("FAIL ie_ffff: got %h expected 1f", d);
        end
        rd(16'hFEA0, d);
        checks++;
        if (d !== 8'hFF) begin
            errors++;
            $display("FAIL unmapped_fea0: got %h expected ff", d);
        end
        rd(16'hA000, d);
        checks++;
        if (d !== 8'hFF) begin
            errors++;
            $display("FAIL unmapped_a000: got %h expected ff", d);
        end
    endtask

    task automatic preload();
        for (int i = 0; i < 160; i++) begin
            wr(16'hC100 + 16'(i), c1_byte(i));
            wr(16'hC200 + 16'(i), c2_byte(i));
        end
    endtask

`ifdef SM83_BUS_OAM_DMA_EN
    // Waits for dma_active to fall; n is the number of high samples so far
    task automatic wait_done(input int n_in, output int n_out);
        int n;
        n = n_in;
        while (n < 400) begin
            tick();
            if (dma_active !== 1'b1) break;
            n++;
        end
        checks++;
        if (n >= 400) begin
            errors++;
            $display("FAIL dma_timeout: got %0d cycles expected 161", n);
        end
        n_out = n;
    endtask

    task automatic test_dma_copy();
        logic [7:0] d;
        int n;
        wr(16'hFF46, 8'hC1);
        checks++;
        if (dma_active !== 1'b1) begin
            errors++;
            $display("FAIL dma_rise: got %b expected 1", dma_active);
        end
        rd(16'hC100, d);
        checks++;
        if (d !== 8'hA5) begin
            errors++;
            $display("FAIL dma_start_unblocked: got %h expected a5", d);
        end
        tick();
        rd(16'hC100, d);
        checks++;
        if (d !== 8'hFF) begin
            errors++;
            $display("FAIL dma_active_blocked: got %h expected ff", d);
        end
        wr(16'hFF90, 8'h3C);
        rd(16'hFF90, d);
        checks++;
        if (d !== 8'h3C) begin
            errors++;
            $display("FAIL dma_hram_ff90: got %h expected 3c", d);
        end
        wr(16'hFE05, 8'h00);
        wait_done(4, n);
        checks++;
        if (n !== 161) begin
            errors++;
            $display("FAIL dma_active_len: got %0d expected 161", n);
        end
        for (int i = 0; i < 160; i++) begin
            rd(16'hFE00 + 16'(i), d);
            checks++;
            if (d !== c1_byte(i)) begin
                errors++;
                $display("FAIL dma_oam[%0d]: got %h expected %h", i, d, c1_byte(i));
            end
        end
        rd(16'hFF46, d);
        checks++;
        if (d !== 8'hC1) begin
            errors++;
            $display("FAIL dma_ff46: got %h expected c1", d);
        end
    endtask

    task automatic test_dma_restart();
        logic [7:0] d;
        int n;
        wr(16'hFF46, 8'hC1);
        tick();
        repeat (50) tick();
        wr(16'hFF46, 8'hC2);
        rd(16'hC100, d);
        checks++;
        if (dma_active !== 1'b1 || d !== 8'hA5) begin
            errors++;
            $display("FAIL restart_start: got act=%b rd=%h expected act=1 rd=a5", dma_active, d);
        end
        wait_done(1, n);
        checks++;
        if (n !== 161) begin
            errors++;
            $display("FAIL restart_len: got %0d expected 161", n);
        end
        for (int i = 0; i < 160; i++) begin
            rd(16'hFE00 + 16'(i), d);
            checks++;
            if (d !== c2_byte(i)) begin
                errors++;
                $display("FAIL restart_oam[%0d]: got %h expected %h", i, d, c2_byte(i));
            end
        end
    endtask

    task automatic test_reset_mid_dma();
        logic [7:0] d;
        wr(16'hFF46, 8'hC1);
        tick();
        repeat (20) tick();
        rst = 1'b1;
        #1;
        checks++;
        if (dma_active !== 1'b0) begin
            errors++;
            $display("FAIL midrst_dma_active: got %b expected 0", dma_active);
        end
        rd(16'hFF46, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL midrst_ff46: got %h expected 00", d);
        end
        rd(16'hC100, d);
        checks++;
        if (d !== 8'hA5) begin
            errors++;
            $display("FAIL midrst_unblocked: got %h expected a5", d);
        end
        rd(16'hFFFF, d);
        checks++;
        if (d !== 8'h00) begin
            errors++;
            $display("FAIL midrst_ie: got %h expected 00", d);
        end
        #2;
        rst = 1'b0;
        tick();
        for (int i = 0; i < 21; i++) begin
            rd(16'hFE00 + 16'(i), d);
            checks++;
            if (d !== ((i < 20) ? c1_byte(i) : c2_byte(i))) begin
                errors++;
                $display("FAIL midrst_oam[%0d]: got %h expected %h", i, d,
                         (i < 20) ? c1_byte(i) : c2_byte(i));
            end
        end
    endtask
`else
    task automatic test_ff46_plain();
        logic [7:0] d;
        int hi;
        hi = 0;
        wr(16'hFF46, 8'hC1);
        repeat (4) begin
            if (dma_active !== 1'b0) hi++;
            tick();
        end
        checks++;
        if (hi !== 0) begin
            errors++;
            $display("FAIL plain_dma_active: got %0d high samples expected 0", hi);
        end
        rd(16'hFF46, d);
        checks++;
        if (d !== 8'hC1) begin
            errors++;
            $display("FAIL plain_ff46: got %h expected c1", d);
        end
        rd(16'hC100, d);
        checks++;
        if (d !== 8'hA5) begin
            errors++;
            $display("FAIL plain_unblocked: got %h expected a5", d);
        end
        wr(16'hFE07, 8'h6E);
        rd(16'hFE07, d);
        checks++;
        if (d !== 8'h6E) begin
            errors++;
            $display("FAIL plain_oam_write: got %h expected 6e", d);
        end
        rd(16'h0456, d);
        checks++;
        if (rom_addr !== 15'h0456 || d !== 8'h52) begin
            errors++;
            $display("FAIL plain_rom: got addr=%h d=%h expected addr=0456 d=52", rom_addr, d);
        end
    endtask
`endif

    initial begin
        rst    = 1'b1;
        r_addr = 16'h0000;
        w_addr = 16'h0000;
        w_data = 8'h00;
        w_wen  = 1'b0;
        test_reset();
        test_wram_echo();
        test_rom();
        test_hram_ie_unmapped();
        preload();
`ifdef SM83_BUS_OAM_DMA_EN
        test_dma_copy();
        test_dma_restart();
        test_reset_mid_dma();
`else
        test_ff46_plain();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
